// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-slot allocator and the display driver.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEARCH     = 2'd1,
        ENTRY_OPEN = 2'd2,
        EXIT_OPEN  = 2'd3
    } state_t;

    localparam int          SLOT_W        = 4;
    localparam logic [3:0]  NO_SLOT       = 4'd0;
    localparam int          NUM_SLOTS_DEF = 8;

endpackage

// File: rtl/slot_allocator_if.sv
// Gate-sensor requests in, occupancy status and barrier controls out.
interface slot_allocator_if;

    logic                           entry_req;
    logic                           exit_req;
    logic [parking_pkg::SLOT_W-1:0] exit_slot;
    logic [parking_pkg::SLOT_W-1:0] available_slots;
    logic [parking_pkg::SLOT_W-1:0] assigned_slot;
    logic                           entry_gate;
    logic                           exit_gate;
    logic                           full;
    logic                           exit_err;

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output available_slots, assigned_slot, entry_gate, exit_gate, full, exit_err
    );

    modport master (
        output entry_req, exit_req, exit_slot,
        input  available_slots, assigned_slot, entry_gate, exit_gate, full, exit_err
    );

endinterface

// File: rtl/req_edge_latch.sv
// Rising-edge detector feeding a one-deep pending flag with optional data capture.
module req_edge_latch #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic              pending_o,
    output logic [DATA_W-1:0] data_o,
    output logic              drop_o
);

    logic              prev_q;
    logic              pend_q;
    logic [DATA_W-1:0] data_q;
    logic              rise;
    logic              accept;

    // A rise coinciding with the consumer's clear is a fresh request, not an overflow.
    assign rise   = req_i & ~prev_q;
    assign accept = rise & (~pend_q | clear_i);
    assign drop_o = rise & pend_q & ~clear_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            prev_q <= req_i;
            pend_q <= accept | (pend_q & ~clear_i);
            if (accept) begin
                data_q <= data_i;
            end
        end
    end

    assign pending_o = pend_q;
    assign data_o    = data_q;

endmodule

// File: rtl/slot_allocator.sv
// Parking-slot occupancy: lowest-free-slot allocation on entry, release on exit, barrier timing.
module slot_allocator
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int GATE_HOLD = 1000
) (
    input  logic              clk,
    input  logic              reset,
    slot_allocator_if.slave   bus
);

    localparam int HOLD_W = $clog2(GATE_HOLD + 1);

    state_t                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   occ_q, occ_d;
    logic [SLOT_W-1:0]      avail_q, avail_d;
    logic [SLOT_W-1:0]      assigned_q, assigned_d;
    logic [SLOT_W-1:0]      scan_q, scan_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   full_q;
    logic                   err_q, err_d;

    logic                   pend_entry, pend_exit;
    logic                   clr_entry, clr_exit;
    logic                   exit_drop;
    logic [SLOT_W-1:0]      pend_slot;
    logic                   entry_drop_unused;
    logic [0:0]             entry_data_unused;

    logic [NUM_SLOTS-1:0]   scan_sel;
    logic [NUM_SLOTS-1:0]   exit_sel;
    logic                   scan_occ;
    logic                   exit_valid;

    req_edge_latch #(.DATA_W(1)) u_entry_latch (
        .clk       (clk),
        .reset     (reset),
        .req_i     (bus.entry_req),
        .data_i    (1'b0),
        .clear_i   (clr_entry),
        .pending_o (pend_entry),
        .data_o    (entry_data_unused),
        .drop_o    (entry_drop_unused)
    );

    req_edge_latch #(.DATA_W(SLOT_W)) u_exit_latch (
        .clk       (clk),
        .reset     (reset),
        .req_i     (bus.exit_req),
        .data_i    (bus.exit_slot),
        .clear_i   (clr_exit),
        .pending_o (pend_exit),
        .data_o    (pend_slot),
        .drop_o    (exit_drop)
    );

    // One-hot decodes; out-of-range slot numbers decode to all zeros and so never validate.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_sel
            assign scan_sel[gi] = (scan_q == SLOT_W'(gi));
            assign exit_sel[gi] = (pend_slot == SLOT_W'(gi + 1));
        end
    endgenerate

    assign scan_occ   = |(occ_q & scan_sel);
    assign exit_valid = |(occ_q & exit_sel);

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        avail_d    = avail_q;
        assigned_d = assigned_q;
        scan_d     = scan_q;
        hold_d     = hold_q;
        err_d      = exit_drop;
        clr_entry  = 1'b0;
        clr_exit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_exit) begin
                    clr_exit = 1'b1;
                    if (exit_valid) begin
                        occ_d   = occ_q & ~exit_sel;
                        avail_d = avail_q + SLOT_W'(1);
                        hold_d  = HOLD_W'(GATE_HOLD);
                        state_d = EXIT_OPEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (pend_entry) begin
                    clr_entry = 1'b1;
                    if (!full_q) begin
                        scan_d  = '0;
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (scan_q >= SLOT_W'(NUM_SLOTS)) begin
                    state_d = IDLE;
                end else if (!scan_occ) begin
                    occ_d      = occ_q | scan_sel;
                    assigned_d = scan_q + SLOT_W'(1);
                    avail_d    = avail_q - SLOT_W'(1);
                    hold_d     = HOLD_W'(GATE_HOLD);
                    state_d    = ENTRY_OPEN;
                end else begin
                    scan_d = scan_q + SLOT_W'(1);
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            avail_q    <= SLOT_W'(NUM_SLOTS);
            assigned_q <= NO_SLOT;
            scan_q     <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            avail_q    <= avail_d;
            assigned_q <= assigned_d;
            scan_q     <= scan_d;
            hold_q     <= hold_d;
            full_q     <= (avail_d == '0);
            err_q      <= err_d;
        end
    end

    assign bus.available_slots = avail_q;
    assign bus.assigned_slot   = assigned_q;
    assign bus.entry_gate      = (state_q == ENTRY_OPEN);
    assign bus.exit_gate       = (state_q == EXIT_OPEN);
    assign bus.full            = full_q;
    assign bus.exit_err        = err_q;

endmodule

// File: tb/tb_slot_allocator.sv
// Directed scenarios for slot_allocator with hand-computed expectations.
module tb_slot_allocator;

    localparam int G = 5;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    slot_allocator_if bus();

    slot_allocator #(.NUM_SLOTS(8), .GATE_HOLD(G)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Counts posedges until the chosen gate is seen high (-1 if never), then how long it stays high.
    task automatic measure_gate(input bit is_exit, output int lat, output int width);
        logic g;
        lat = -1;
        width = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            g = is_exit ? bus.exit_gate : bus.entry_gate;
            if (g === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            width = 1;
            for (int c = 0; c < 100; c++) begin
                @(posedge clk); #1;
                g = is_exit ? bus.exit_gate : bus.entry_gate;
                if (g === 1'b1) width++;
                else break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req = 1'b0;
        bus.exit_slot = 4'd0;
        #12;
        total_cnt++; if (bus.available_slots !== 4'd8) $display("FAIL reset_avail: got %0d expected 8", bus.available_slots); else pass_cnt++;
        total_cnt++; if (bus.assigned_slot !== 4'd0) $display("FAIL reset_assigned: got %0d expected 0", bus.assigned_slot); else pass_cnt++;
        total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.full); else pass_cnt++;
        total_cnt++; if ({bus.entry_gate, bus.exit_gate, bus.exit_err} !== 3'b000) $display("FAIL reset_gates: got %b expected 000", {bus.entry_gate, bus.exit_gate, bus.exit_err}); else pass_cnt++;
        @(negedge clk); reset = 1'b0;
        $display("reset released: avail=%0d assigned=%0d", bus.available_slots, bus.assigned_slot);
    endtask

    task automatic test_reset_mid_search();
        int lat, w;
        @(negedge clk); bus.entry_req = 1'b1;
        measure_gate(1'b0, lat, w);
        @(negedge clk); bus.entry_req = 1'b0;
        total_cnt++; if (bus.assigned_slot !== 4'd1) $display("FAIL pre_reset_assigned: got %0d expected 1", bus.assigned_slot); else pass_cnt++;
        @(negedge clk); bus.entry_req = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        bus.entry_req = 1'b0;
        #1;
        total_cnt++; if (bus.available_slots !== 4'd8) $display("FAIL midsearch_avail: got %0d expected 8", bus.available_slots); else pass_cnt++;
        total_cnt++; if (bus.assigned_slot !== 4'd0) $display("FAIL midsearch_assigned: got %0d expected 0", bus.assigned_slot); else pass_cnt++;
        total_cnt++; if ({bus.entry_gate, bus.full} !== 2'b00) $display("FAIL midsearch_gate_full: got %b expected 00", {bus.entry_gate, bus.full}); else pass_cnt++;
        @(negedge clk); reset = 1'b0;
        repeat (6) @(posedge clk); #1;
        total_cnt++; if (bus.assigned_slot !== 4'd0 || bus.entry_gate !== 1'b0) $display("FAIL post_reset_idle: got assigned=%0d gate=%b expected 0/0", bus.assigned_slot, bus.entry_gate); else pass_cnt++;
        $display("reset during search: avail=%0d assigned=%0d", bus.available_slots, bus.assigned_slot);
    endtask

    task automatic test_three_entries();
        int lat, w;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.entry_req = 1'b1;
            measure_gate(1'b0, lat, w);
            @(negedge clk); bus.entry_req = 1'b0;
            $display("entry: slot=%0d avail=%0d lat=%0d width=%0d", bus.assigned_slot, bus.available_slots, lat, w);
            total_cnt++; if (lat !== 3 + i) $display("FAIL entry_lat: got %0d expected %0d", lat, 3 + i); else pass_cnt++;
            total_cnt++; if (w !== G) $display("FAIL entry_width: got %0d expected %0d", w, G); else pass_cnt++;
            total_cnt++; if (bus.assigned_slot !== 4'(i + 1)) $display("FAIL entry_slot: got %0d expected %0d", bus.assigned_slot, i + 1); else pass_cnt++;
            total_cnt++; if (bus.available_slots !== 4'(7 - i)) $display("FAIL entry_avail: got %0d expected %0d", bus.available_slots, 7 - i); else pass_cnt++;
        end
    endtask

    task automatic test_exit_refill();
        int lat, w;
        @(negedge clk); bus.exit_slot = 4'd2; bus.exit_req = 1'b1;
        measure_gate(1'b1, lat, w);
        @(negedge clk); bus.exit_req = 1'b0;
        $display("exit: slot=2 avail=%0d lat=%0d width=%0d", bus.available_slots, lat, w);
        total_cnt++; if (lat !== 2) $display("FAIL exit_lat: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (w !== G) $display("FAIL exit_width: got %0d expected %0d", w, G); else pass_cnt++;
        total_cnt++; if (bus.available_slots !== 4'd6) $display("FAIL exit_avail: got %0d expected 6", bus.available_slots); else pass_cnt++;
        @(negedge clk); bus.entry_req = 1'b1;
        measure_gate(1'b0, lat, w);
        @(negedge clk); bus.entry_req = 1'b0;
        $display("entry: slot=%0d avail=%0d lat=%0d", bus.assigned_slot, bus.available_slots, lat);
        total_cnt++; if (lat !== 4) $display("FAIL refill_lat: got %0d expected 4", lat); else pass_cnt++;
        total_cnt++; if (bus.assigned_slot !== 4'd2) $display("FAIL refill_slot: got %0d expected 2", bus.assigned_slot); else pass_cnt++;
        total_cnt++; if (bus.available_slots !== 4'd5) $display("FAIL refill_avail: got %0d expected 5", bus.available_slots); else pass_cnt++;
    endtask

    task automatic test_fill_full();
        int lat, w;
        for (int s = 4; s <= 8; s++) begin
            @(negedge clk); bus.entry_req = 1'b1;
            measure_gate(1'b0, lat, w);
            @(negedge clk); bus.entry_req = 1'b0;
            $display("entry: slot=%0d avail=%0d full=%b", bus.assigned_slot, bus.available_slots, bus.full);
            total_cnt++; if (bus.assigned_slot !== 4'(s) || lat !== s + 2) $display("FAIL fill_slot: got slot=%0d lat=%0d expected %0d/%0d", bus.assigned_slot, lat, s, s + 2); else pass_cnt++;
        end
        total_cnt++; if (bus.available_slots !== 4'd0) $display("FAIL full_avail: got %0d expected 0", bus.available_slots); else pass_cnt++;
        total_cnt++; if (bus.full !== 1'b1) $display("FAIL full_flag: got %b expected 1", bus.full); else pass_cnt++;
        @(negedge clk); bus.entry_req = 1'b1;
        measure_gate(1'b0, lat, w);
        @(negedge clk); bus.entry_req = 1'b0;
        $display("entry while full: lat=%0d assigned=%0d", lat, bus.assigned_slot);
        total_cnt++; if (lat !== -1) $display("FAIL full_no_gate: got lat %0d expected -1 (no gate)", lat); else pass_cnt++;
        total_cnt++; if (bus.assigned_slot !== 4'd8) $display("FAIL full_assigned: got %0d expected 8", bus.assigned_slot); else pass_cnt++;
        @(negedge clk); bus.exit_slot = 4'd5; bus.exit_req = 1'b1;
        measure_gate(1'b1, lat, w);
        @(negedge clk); bus.exit_req = 1'b0;
        $display("exit: slot=5 avail=%0d full=%b", bus.available_slots, bus.full);
        total_cnt++; if (bus.full !== 1'b0 || bus.available_slots !== 4'd1) $display("FAIL unfull: got full=%b avail=%0d expected 0/1", bus.full, bus.available_slots); else pass_cnt++;
    endtask

    task automatic test_invalid_exits();
        int lat, w;
        logic [3:0] bad [3];
        bad[0] = 4'd0; bad[1] = 4'd9; bad[2] = 4'd4;
        @(negedge clk); bus.exit_slot = 4'd4; bus.exit_req = 1'b1;
        measure_gate(1'b1, lat, w);
        @(negedge clk); bus.exit_req = 1'b0;
        total_cnt++; if (lat !== 2 || bus.available_slots !== 4'd2) $display("FAIL exit4: got lat=%0d avail=%0d expected 2/2", lat, bus.available_slots); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            logic e1, e2, e3;
            @(negedge clk); bus.exit_slot = bad[i]; bus.exit_req = 1'b1;
            @(posedge clk); #1; e1 = bus.exit_err;
            @(posedge clk); #1; e2 = bus.exit_err;
            @(posedge clk); #1; e3 = bus.exit_err;
            @(negedge clk); bus.exit_req = 1'b0;
            $display("bad exit: slot=%0d err=%b%b%b avail=%0d", bad[i], e1, e2, e3, bus.available_slots);
            total_cnt++; if ({e1, e2, e3} !== 3'b010) $display("FAIL bad_exit_err: got %b%b%b expected 010", e1, e2, e3); else pass_cnt++;
            total_cnt++; if (bus.available_slots !== 4'd2 || bus.exit_gate !== 1'b0) $display("FAIL bad_exit_state: got avail=%0d gate=%b expected 2/0", bus.available_slots, bus.exit_gate); else pass_cnt++;
        end
        @(negedge clk); bus.entry_req = 1'b1;
        measure_gate(1'b0, lat, w);
        @(negedge clk); bus.entry_req = 1'b0;
        $display("entry: slot=%0d avail=%0d", bus.assigned_slot, bus.available_slots);
        total_cnt++; if (bus.assigned_slot !== 4'd4 || bus.available_slots !== 4'd1) $display("FAIL after_bad_entry: got slot=%0d avail=%0d expected 4/1", bus.assigned_slot, bus.available_slots); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int lat, w;
        @(negedge clk); bus.exit_slot = 4'd1; bus.exit_req = 1'b1; bus.entry_req = 1'b1;
        measure_gate(1'b1, lat, w);
        $display("simultaneous exit: lat=%0d avail=%0d", lat, bus.available_slots);
        total_cnt++; if (lat !== 2 || w !== G) $display("FAIL simul_exit: got lat=%0d width=%0d expected 2/%0d", lat, w, G); else pass_cnt++;
        total_cnt++; if (bus.available_slots !== 4'd2) $display("FAIL simul_exit_avail: got %0d expected 2", bus.available_slots); else pass_cnt++;
        measure_gate(1'b0, lat, w);
        @(negedge clk); bus.exit_req = 1'b0; bus.entry_req = 1'b0;
        $display("simultaneous entry: slot=%0d lat=%0d avail=%0d", bus.assigned_slot, lat, bus.available_slots);
        total_cnt++; if (lat !== 2) $display("FAIL simul_entry_lat: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (bus.assigned_slot !== 4'd1 || bus.available_slots !== 4'd1) $display("FAIL simul_entry: got slot=%0d avail=%0d expected 1/1", bus.assigned_slot, bus.available_slots); else pass_cnt++;
    endtask

    task automatic test_exit_drop();
        int  lat, w;
        logic seen;
        seen = 1'b0;
        @(negedge clk); bus.entry_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.entry_gate === 1'b1) begin seen = 1'b1; break; end
        end
        total_cnt++; if (seen !== 1'b1 || bus.assigned_slot !== 4'd5 || bus.full !== 1'b1) $display("FAIL drop_entry: got gate=%b slot=%0d full=%b expected 1/5/1", seen, bus.assigned_slot, bus.full); else pass_cnt++;
        @(negedge clk); bus.entry_req = 1'b0; bus.exit_slot = 4'd2; bus.exit_req = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus.exit_err !== 1'b0) $display("FAIL drop_first: got %b expected 0", bus.exit_err); else pass_cnt++;
        @(negedge clk); bus.exit_req = 1'b0;
        @(negedge clk); bus.exit_req = 1'b1; bus.exit_slot = 4'd9;
        @(posedge clk); #1;
        total_cnt++; if (bus.exit_err !== 1'b1) $display("FAIL drop_pulse: got %b expected 1", bus.exit_err); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.exit_err !== 1'b0) $display("FAIL drop_pulse_end: got %b expected 0", bus.exit_err); else pass_cnt++;
        measure_gate(1'b1, lat, w);
        @(negedge clk); bus.exit_req = 1'b0;
        $display("queued exit after drop: lat=%0d avail=%0d full=%b", lat, bus.available_slots, bus.full);
        total_cnt++; if (lat !== 2) $display("FAIL drop_served_lat: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (bus.available_slots !== 4'd1 || bus.full !== 1'b0) $display("FAIL drop_served: got avail=%0d full=%b expected 1/0", bus.available_slots, bus.full); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_search();
        test_three_entries();
        test_exit_refill();
        test_fill_full();
        test_invalid_exits();
        test_simultaneous();
        test_exit_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/slot_allocator.md
Name: slot_allocator

Overview:
- Upstream stage of the 7-segment display driver; owns parking-slot occupancy.
- Takes car-entry and car-exit requests from gate sensors and allocates the lowest-numbered free slot to each entering car.
- Frees slots on exit and times the entry and exit barrier gates.
- Produces the `available_slots` count and `assigned_slot` number that the display driver shows.

Parameters:
- NUM_SLOTS, 8, number of parking slots (legal 1..15). Slots are numbered 1..NUM_SLOTS; 0 means "none".
- GATE_HOLD, 1000, cycles a barrier gate stays open (legal >=2). Width of the hold counter is $clog2(GATE_HOLD+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- entry_req  in  1  entry sensor, synchronous level; a rising edge is one request
- exit_req  in  1  exit sensor, synchronous level; a rising edge is one request
- exit_slot  in  4  slot number being vacated, sampled on the exit_req rising edge
- available_slots  out  4  free-slot count, registered
- assigned_slot  out  4  slot given to the most recent entering car, 0 if none yet
- entry_gate  out  1  entry barrier open
- exit_gate  out  1  exit barrier open
- full  out  1  high when available_slots==0, registered
- exit_err  out  1  one-cycle pulse on an invalid or dropped exit request

Behaviour:
- Reset (async, immediate):
  - occupancy bitmap = 0, available_slots = NUM_SLOTS, assigned_slot = 0.
  - entry_gate = 0, exit_gate = 0, full = 0, exit_err = 0.
  - FSM = IDLE; pending flags and edge-detect registers cleared. Reset mid-search or mid-gate simply aborts.
- Edge detect: entry_req and exit_req each pass through one register; rise = in & ~prev.
- Pending latches:
  - An entry rise sets pending_entry; a second entry rise while it is set is absorbed.
  - An exit rise sets pending_exit and captures exit_slot into pend_slot.
  - An exit rise while pending_exit is already set is dropped and pulses exit_err.
- FSM states: IDLE, SEARCH, ENTRY_OPEN, EXIT_OPEN.
- IDLE:
  - If pending_exit: validate pend_slot and clear pending_exit.
  - Valid means 1..NUM_SLOTS with the occupied bit set: clear the bit, available_slots+1, go to EXIT_OPEN.
  - Invalid: exit_err pulse, stay IDLE.
  - Exit has priority over entry on simultaneous pendings.
  - Else if pending_entry and full: discard the request (clear pending_entry), gate stays closed, assigned_slot unchanged.
  - Else if pending_entry: clear pending_entry, scan_idx = 0, go to SEARCH.
- SEARCH:
  - Examines bitmap[scan_idx], one slot per cycle.
  - On a free slot: set the bit, assigned_slot = scan_idx+1, available_slots-1, hold counter = GATE_HOLD, go to ENTRY_OPEN.
  - Otherwise scan_idx+1.
  - A free slot is guaranteed because full was checked; if scan_idx reaches NUM_SLOTS anyway, return to IDLE with no change.
- Search latency: the lowest free slot j (0-based) is allocated at the clock edge j+1 cycles after SEARCH entry; entry_gate rises on that same edge.
- ENTRY_OPEN / EXIT_OPEN:
  - The matching gate output is 1.
  - The hold counter decrements each cycle; at 1 the gate drops and the FSM returns to IDLE.
  - Each gate is open for exactly GATE_HOLD cycles.
- Requests arriving in non-IDLE states are latched per the pending rules and served on return to IDLE.
- full = (available_slots==0), registered in the same edge as the count update.
- available_slots never wraps: the count is only changed on a verified bitmap-bit flip.
- assigned_slot holds its value across exits and is overwritten only by the next allocation.

Decomposition:
- Shared package `parking_pkg`:
  - FSM state enum (IDLE/SEARCH/ENTRY_OPEN/EXIT_OPEN).
  - SLOT_W = 4.
  - NO_SLOT = 4'd0.
  - The NUM_SLOTS default, shared with the display driver.
- Sub-module `req_edge_latch`, instantiated twice (entry, exit):
  - Rising-edge detect plus pending flag, with optional data capture.
  - Drop-pulse output on overflow.
- The FSM, bitmap, counter and gate timer remain in slot_allocator.

Test Plan:
1. Reset -> available_slots=8, assigned_slot=0, full=0, both gates 0. Assert reset mid-SEARCH -> all outputs return to these values immediately.
2. Three entry pulses, each after the gate closes -> assigned_slot 1,2,3; available_slots 7,6,5; entry_gate high exactly GATE_HOLD cycles each.
3. With slots 1-3 occupied, exit_slot=2 -> exit_gate opens, available_slots=6. Next entry -> assigned_slot=2 (lowest free), found 2 cycles after SEARCH entry.
4. Fill all 8 slots -> full=1, available_slots=0. Further entry pulse -> no gate, assigned_slot stays 8. Exit slot 5 -> full=0.
5. Exit with exit_slot=0, exit_slot=9, and an unoccupied slot 4 -> exit_err single-cycle pulse each; count and bitmap unchanged.
6. entry_req and exit_req (slot 1 occupied) rise in the same cycle -> exit served first (exit_gate); after it closes, SEARCH reallocates slot 1.
